// File: rtl/pi_digit_stream.sv
// pi_digit_stream
//   Streams BCD digits of pi out of a DPD-packed word memory. A request
//   (start index, digit count) is taken on a valid/ready handshake. Declets
//   are fetched two words at a time, decoded, and the digits are pushed into
//   a small buffer. They leave LANES digits per beat on a valid/ready stream.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o request handshake
//   req_index_i             first digit index
//   req_count_i             digits requested (clamped to the image size)
//   mem_addr_o, mem_q_i     word address out; data returns one cycle later
//   out_valid_o/out_ready_i output beat handshake
//   out_digits_o            LANES BCD digits, lane 0 in [3:0] is the earliest
//   out_count_o             number of valid lanes in the beat (0..LANES)
//   out_last_o              final beat of the request
module pi_digit_stream #(
  parameter int N      = 24,
  parameter int MEM_W  = 18,
  parameter int LANES  = 4,
  parameter int DIGITS = 3000000
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [N-1:0]       req_index_i,
  input  logic [N-1:0]       req_count_i,
  output logic [N-1:0]       mem_addr_o,
  input  logic [MEM_W-1:0]   mem_q_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [4*LANES-1:0] out_digits_o,
  output logic [3:0]         out_count_o,
  output logic               out_last_o
);
  localparam int DEPTH = LANES + 2;
  localparam int SW    = $clog2(MEM_W + 10);
  localparam int BW    = N + 4;
  localparam logic [N-1:0]  DIGITS_N = N'(DIGITS);
  localparam logic [BW-1:0] MEM_W_B  = BW'(MEM_W);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPTURE, S_FILL, S_EMIT, S_EMPTY} state_e;

  // DPD declet -> three BCD digits {hi, mid, lo}.
  function automatic logic [11:0] dpd_decode(input logic [9:0] d);
    logic p, q, r, s, t, u, v, w, x, y;
    logic [3:0] h, m, l;
    {p, q, r, s, t, u, v, w, x, y} = d;
    h = {1'b0, p, q, r};
    m = {1'b0, s, t, u};
    l = {1'b0, w, x, y};
    if (v) begin
      case ({w, x})
        2'b00: l = {3'b100, y};
        2'b01: begin m = {3'b100, u}; l = {1'b0, s, t, y}; end
        2'b10: begin h = {3'b100, r}; l = {1'b0, p, q, y}; end
        default: begin
          case ({s, t})
            2'b00: begin h = {3'b100, r}; m = {3'b100, u}; l = {1'b0, p, q, y}; end
            2'b01: begin h = {3'b100, r}; m = {1'b0, p, q, u}; l = {3'b100, y}; end
            2'b10: begin m = {3'b100, u}; l = {3'b100, y}; end
            default: begin h = {3'b100, r}; m = {3'b100, u}; l = {3'b100, y}; end
          endcase
        end
      endcase
    end
    return {h, m, l};
  endfunction

  state_e                   state_q;
  logic                     phase_q;     // ADDR sub-cycle: 0 -> word a, 1 -> word a+1
  logic [N-1:0]             a_q;         // word address of the current declet
  logic [SW-1:0]            s_q;         // bit offset of the current declet in word a
  logic [1:0]               skip_q;      // leading digits to drop from the first declet
  logic [N-1:0]             fetch_q;     // digits still to be pushed into the buffer
  logic [N-1:0]             rem_q;       // digits still to be emitted
  logic [MEM_W-1:0]         lo_q;
  logic [11:0]              dec_q;
  logic [DEPTH-1:0][3:0]    buf_q;       // entry 0 is the oldest digit
  logic [3:0]               bcnt_q;
  logic [N-1:0]             mem_addr_q;
  logic                     req_ready_q;
  logic                     out_valid_q;
  logic [4*LANES-1:0]       out_digits_q;
  logic [3:0]               out_count_q;
  logic                     out_last_q;

  // Accept-time arithmetic: clamp the count and locate the first declet.
  logic [N-1:0]  avail, eff_cnt;
  logic [BW-1:0] bitpos0;
  always_comb begin
    avail   = DIGITS_N - req_index_i;
    eff_cnt = (req_index_i >= DIGITS_N) ? '0 :
              ((req_count_i < avail) ? req_count_i : avail);
    bitpos0 = BW'(req_index_i / N'(3)) * BW'(10);
  end

  // Declet extraction from the two-word window and step to the next declet.
  logic [2*MEM_W-1:0] pair;
  logic [9:0]         declet;
  logic [SW-1:0]      s_sum;
  logic               s_wrap;
  always_comb begin
    pair   = {mem_q_i, lo_q};
    declet = 10'(pair >> s_q);
    s_sum  = s_q + SW'(10);
    s_wrap = (s_sum >= SW'(MEM_W));
  end

  // Push of the decoded digits, honouring the skip and the remaining count.
  logic [1:0]            take;
  logic [DEPTH-1:0][3:0] push_buf;
  logic [3:0]            push_cnt;
  always_comb begin
    take = 2'd3 - skip_q;
    if (fetch_q < N'(take)) take = fetch_q[1:0];
    push_buf = buf_q;
    push_cnt = bcnt_q;
    for (int j = 0; j < 3; j++) begin
      if (j >= int'(skip_q) && j < int'(skip_q) + int'(take)) begin
        for (int p = 0; p < DEPTH; p++)
          if (p == int'(push_cnt)) push_buf[p] = dec_q[4*(2-j) +: 4];
        push_cnt = push_cnt + 4'd1;
      end
    end
  end

  // Pop of the beat being handed off.
  logic [DEPTH-1:0][3:0] pop_buf;
  logic [3:0]            pop_cnt;
  logic [N-1:0]          pop_rem;
  always_comb begin
    pop_buf = buf_q >> {out_count_q, 2'b00};
    pop_cnt = bcnt_q - out_count_q;
    pop_rem = rem_q - N'(out_count_q);
  end

  // Next beat, built from the buffer as it will look after this cycle.
  logic [DEPTH-1:0][3:0] src_buf;
  logic [3:0]            src_cnt, beat_n;
  logic [N-1:0]          src_rem;
  logic [4*LANES-1:0]    beat_d;
  logic                  beat_last;
  always_comb begin
    src_buf = (state_q == S_FILL) ? push_buf : pop_buf;
    src_cnt = (state_q == S_FILL) ? push_cnt : pop_cnt;
    src_rem = (state_q == S_FILL) ? rem_q    : pop_rem;
    beat_n  = (src_cnt < 4'(LANES)) ? src_cnt : 4'(LANES);
    beat_d  = '0;
    for (int l = 0; l < LANES; l++)
      if (4'(l) < beat_n) beat_d[4*l +: 4] = src_buf[l];
    beat_last = (N'(beat_n) == src_rem);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      a_q          <= '0;
      s_q          <= '0;
      skip_q       <= '0;
      fetch_q      <= '0;
      rem_q        <= '0;
      lo_q         <= '0;
      dec_q        <= '0;
      buf_q        <= '0;
      bcnt_q       <= '0;
      mem_addr_q   <= '0;
      req_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      out_digits_q <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            skip_q      <= 2'(req_index_i % N'(3));
            fetch_q     <= eff_cnt;
            rem_q       <= eff_cnt;
            bcnt_q      <= '0;
            buf_q       <= '0;
            a_q         <= N'(bitpos0 / MEM_W_B);
            s_q         <= SW'(bitpos0 % MEM_W_B);
            if (eff_cnt != '0) begin
              state_q    <= S_ADDR;
              phase_q    <= 1'b0;
              mem_addr_q <= N'(bitpos0 / MEM_W_B);
            end else begin
              state_q      <= S_EMPTY;
              out_valid_q  <= 1'b1;
              out_digits_q <= '0;
              out_count_q  <= '0;
              out_last_q   <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (!phase_q) begin
            phase_q    <= 1'b1;
            mem_addr_q <= a_q + N'(1);
          end else begin
            lo_q    <= mem_q_i;      // word a, returned for last cycle's address
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          dec_q   <= dpd_decode(declet);
          a_q     <= s_wrap ? a_q + N'(1) : a_q;
          s_q     <= s_wrap ? s_sum - SW'(MEM_W) : s_sum;
          state_q <= S_FILL;
        end
        S_FILL: begin
          buf_q   <= push_buf;
          bcnt_q  <= push_cnt;
          fetch_q <= fetch_q - N'(take);
          skip_q  <= '0;
          if (push_cnt >= 4'(LANES) || fetch_q == N'(take)) begin
            state_q      <= S_EMIT;
            out_valid_q  <= 1'b1;
            out_digits_q <= beat_d;
            out_count_q  <= beat_n;
            out_last_q   <= beat_last;
          end else begin
            state_q    <= S_ADDR;
            phase_q    <= 1'b0;
            mem_addr_q <= a_q;
          end
        end
        S_EMIT: begin
          if (out_ready_i) begin
            buf_q  <= pop_buf;
            bcnt_q <= pop_cnt;
            rem_q  <= pop_rem;
            if (out_last_q) begin
              state_q      <= S_IDLE;
              req_ready_q  <= 1'b1;
              out_valid_q  <= 1'b0;
              out_digits_q <= '0;
              out_count_q  <= '0;
              out_last_q   <= 1'b0;
            end else if (pop_cnt >= 4'(LANES) || fetch_q == '0) begin
              // Enough buffered (or nothing left to fetch): next beat straight away.
              out_digits_q <= beat_d;
              out_count_q  <= beat_n;
              out_last_q   <= beat_last;
            end else begin
              state_q      <= S_ADDR;
              phase_q      <= 1'b0;
              mem_addr_q   <= a_q;
              out_valid_q  <= 1'b0;
              out_digits_q <= '0;
              out_count_q  <= '0;
              out_last_q   <= 1'b0;
            end
          end
        end
        S_EMPTY: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign mem_addr_o   = mem_addr_q;
  assign out_valid_o  = out_valid_q;
  assign out_digits_o = out_digits_q;
  assign out_count_o  = out_count_q;
  assign out_last_o   = out_last_q;

endmodule

// File: tb/tb_pi_digit_stream.sv
// Bench for pi_digit_stream. The memory image is built from a digit table
// through a BCD->DPD encoder; expected beats are slices of that digit table.
module tb_pi_digit_stream;
  localparam int N      = 24;
  localparam int MEM_W  = 18;
  localparam int LANES  = 4;
  localparam int DIGITS = 3000000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               req_valid, req_ready;
  logic [N-1:0]       req_index, req_count, mem_addr;
  logic [MEM_W-1:0]   mem_q = '0;
  logic               out_valid, out_ready, out_last;
  logic [4*LANES-1:0] out_digits;
  logic [3:0]         out_count;

  int errors = 0;
  int checks = 0;

  string pi_s = "31415926535897932384626433832795028841971693993751058209749445923078164062862089986280348253421170679";

  pi_digit_stream #(.N(N), .MEM_W(MEM_W), .LANES(LANES), .DIGITS(DIGITS)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_index_i(req_index), .req_count_i(req_count),
    .mem_addr_o(mem_addr), .mem_q_i(mem_q),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_digits_o(out_digits), .out_count_o(out_count), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  // Digit image: real pi for the first ~100 digits, a fixed pattern beyond.
  function automatic logic [3:0] digit(input int i);
    if (i < pi_s.len()) return 4'(pi_s[i] - 8'd48);
    return 4'((i * 7 + i / 11) % 10);
  endfunction

  // BCD -> DPD encoder, keyed on which of the three digits are 8 or 9.
  function automatic logic [9:0] dpd_enc(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    case ({a[3], b[3], c[3]})
      3'b000:  return {a[2:0], b[2:0], 1'b0, c[2:0]};
      3'b001:  return {a[2:0], b[2:0], 1'b1, 2'b00, c[0]};
      3'b010:  return {a[2:0], c[2:1], b[0], 1'b1, 2'b01, c[0]};
      3'b011:  return {a[2:0], 2'b10, b[0], 1'b1, 2'b11, c[0]};
      3'b100:  return {c[2:1], a[0], b[2:0], 1'b1, 2'b10, c[0]};
      3'b101:  return {b[2:1], a[0], 2'b01, b[0], 1'b1, 2'b11, c[0]};
      3'b110:  return {c[2:1], a[0], 2'b00, b[0], 1'b1, 2'b11, c[0]};
      default: return {2'b00, a[0], 2'b11, b[0], 1'b1, 2'b11, c[0]};
    endcase
  endfunction

  function automatic logic [MEM_W-1:0] mem_word(input logic [N-1:0] a);
    logic [MEM_W-1:0] w;
    logic [9:0] d;
    longint bitn;
    int k;
    w = '0;
    for (int b = 0; b < MEM_W; b++) begin
      bitn = longint'(a) * MEM_W + b;
      k = int'(bitn / 10);
      d = dpd_enc(digit(3 * k), digit(3 * k + 1), digit(3 * k + 2));
      w[b] = d[int'(bitn % 10)];
    end
    return w;
  endfunction

  always @(posedge clk) mem_q <= mem_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One request end to end. stall < 0 picks a random stall per beat.
  task automatic run_req(input int idx, input int cnt, input int stall);
    int eff, pos, n, nst, beats, bound;
    logic [4*LANES-1:0] exp_d;
    logic exp_last, done;
    logic [N-1:0] iv, cv;
    eff = (idx >= DIGITS) ? 0 : ((cnt < DIGITS - idx) ? cnt : DIGITS - idx);
    iv = idx[N-1:0];
    cv = cnt[N-1:0];
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_index = iv; req_count = cv;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
    pos = 0; beats = 0; done = 1'b0;
    while (!done) begin
      n = (eff - pos < LANES) ? eff - pos : LANES;
      // First beat: at most 4 cycles per declet it spans, plus 1.
      bound = (beats == 0) ? ((eff == 0) ? 1 : 4 * ((idx + n - 1) / 3 - idx / 3 + 1) + 1) : 20;
      wait_valid(bound);
      if (out_valid !== 1'b1) begin
        chk("beat_timeout", out_valid, 1);
        done = 1'b1;
      end else begin
        exp_last = (pos + n == eff);
        exp_d = '0;
        for (int l = 0; l < LANES; l++)
          if (l < n) exp_d[4*l +: 4] = digit(idx + pos + l);
        chk("beat_count", out_count, n);
        chk("beat_last", out_last, exp_last);
        chk("beat_digits", out_digits, exp_d);
        nst = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        for (int s = 0; s < nst; s++) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_digits", out_digits, exp_d);
          chk("stall_count", out_count, n);
          chk("stall_last", out_last, exp_last);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        pos += n;
        beats++;
        done = exp_last || (beats > eff / LANES + 2);
      end
    end
    chk("idle_after", {req_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cnt;
    req_valid = 1'b0; req_index = '0; req_count = '0; out_ready = 1'b0;
    // Asynchronous reset between edges: outputs must clear at once.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_digits", out_digits, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    run_req(0, 6, 0);            // 3141 / 59, declet 1 straddles words 0/1
    run_req(4, 3, 0);            // mid-declet start: 592
    run_req(0, 12, 5);           // backpressure on every beat
    run_req(DIGITS - 2, 5, 0);   // clamp to 2 digits
    run_req(DIGITS, 5, 0);       // out of range: empty beat
    run_req(10, 0, 0);           // zero count: empty beat

    // Reset during the second beat of a 12-digit request.
    @(negedge clk);
    req_valid = 1'b1; req_index = '0; req_count = 24'd12;
    @(negedge clk);
    req_valid = 1'b0;
    wait_valid(20);
    chk("mid_first_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(20);
    chk("mid_second_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_digits", out_digits, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
    end
    run_req(3, 1, 0);            // yields {1}

    // Randomized requests, including ones near and past the image end.
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) idx = DIGITS - 6 + int'($urandom_range(0, 8));
      else idx = int'($urandom_range(0, 120));
      cnt = int'($urandom_range(0, 14));
      run_req(idx, cnt, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
